// File: rtl/bitxor_misr_pkg.sv
// Purpose : shared types, defaults and the MISR update function for the
//           bitwise-XOR result signature-compaction block.
// Contents: misr_state_e (2-bit FSM encoding), default POLY/SEED, misr_next().
package bitxor_misr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        COMPACT = 2'd2,
        DONE    = 2'd3
    } misr_state_e;

    localparam logic [15:0] MISR_POLY_DEFAULT = 16'h8016;
    localparam logic [15:0] MISR_SEED_DEFAULT = 16'hFFFF;

    // Widest signature misr_next can fold; callers zero-extend into it and
    // truncate the return value back to their own width.
    localparam int unsigned MISR_MAX_W = 64;

    // One MISR step at an arbitrary width <= MISR_MAX_W:
    // shift left, fold POLY in when the bit shifted out was 1, XOR in data.
    function automatic logic [MISR_MAX_W-1:0] misr_next(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] poly,
        input logic [MISR_MAX_W-1:0] din,
        input int unsigned           width
    );
        logic [MISR_MAX_W-1:0] mask;
        logic                  msb;
        mask = (width >= MISR_MAX_W) ? {MISR_MAX_W{1'b1}}
                                     : ((64'd1 << width) - 64'd1);
        msb  = |(sig & (64'd1 << (width - 1)));
        return (((sig << 1) ^ (msb ? poly : 64'd0)) ^ din) & mask;
    endfunction

endpackage

// File: rtl/bitxor_misr_reg.sv
// Purpose : BITWIDTH-bit signature register; load forces SEED, enable captures din.
// Latency : din_i visible on sig_o one clk edge after en_i; load beats enable.
// Ports   : clk, rst (async active-high), load_i, en_i, din_i[W], sig_o[W].
module bitxor_misr_reg #(
    parameter int unsigned         W    = 16,
    parameter logic [W-1:0]        SEED = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] sig_o
);

    logic [W-1:0] sig_q;
    logic [W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load_i) begin
            sig_d = SEED;
        end else if (en_i) begin
            sig_d = din_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/bitxor_result_misr.sv
// Purpose : skips WARMUP_CYCLES of upstream latency, folds NUM_SAMPLES results
//           into a MISR and registers a pass/fail compare against expected_sig.
// Latency : done/pass one cycle after the final absorb edge; no input-to-output path.
// Ports   : clk, rst, start, result[W], expected_sig[W] -> busy, done, pass, signature[W].
//           Optional `abort` input when BITXOR_MISR_ABORT_EN is defined.
module bitxor_result_misr
    import bitxor_misr_pkg::*;
#(
    parameter int unsigned           BITWIDTH      = 16,
    parameter int unsigned           WARMUP_CYCLES = 4,
    parameter int unsigned           NUM_SAMPLES   = 256,
    parameter logic [BITWIDTH-1:0]   POLY          = BITWIDTH'(MISR_POLY_DEFAULT),
    parameter logic [BITWIDTH-1:0]   SEED          = BITWIDTH'(MISR_SEED_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst,
`ifdef BITXOR_MISR_ABORT_EN
    input  logic                abort,
`endif
    input  logic                start,
    input  logic [BITWIDTH-1:0] result,
    input  logic [BITWIDTH-1:0] expected_sig,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [BITWIDTH-1:0] signature
);

    localparam int unsigned CNT_MAX = (WARMUP_CYCLES > NUM_SAMPLES) ? WARMUP_CYCLES
                                                                    : NUM_SAMPLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // WARM_LAST is only reachable when WARMUP_CYCLES >= 2; for a one-cycle
    // warm-up the FSM jumps straight into COMPACT and never compares against it.
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP_CYCLES - 2);
    localparam logic [CNT_W-1:0] SAMP_LAST = CNT_W'(NUM_SAMPLES - 1);
    localparam misr_state_e      RUN_ENTRY = (WARMUP_CYCLES == 1) ? COMPACT : WARMUP;

    misr_state_e         state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;

    logic                abort_w;
    logic                start_ok;
    logic                absorb;
    logic [BITWIDTH-1:0] sig_cur;
    logic [BITWIDTH-1:0] sig_next;

`ifdef BITXOR_MISR_ABORT_EN
    // Abort is a no-op in IDLE so that it cannot disturb the reset-like state.
    assign abort_w = abort & (state_q != IDLE);
`else
    assign abort_w = 1'b0;
`endif

    // Abort wins over both a fresh start and the final absorb.
    assign start_ok = start & ((state_q == IDLE) | (state_q == DONE)) & ~abort_w;
    assign absorb   = (state_q == COMPACT) & ~abort_w;

    assign sig_next = BITWIDTH'(misr_next(64'(sig_cur), 64'(POLY), 64'(result), BITWIDTH));

    bitxor_misr_reg #(
        .W    (BITWIDTH),
        .SEED (SEED)
    ) u_misr_reg (
        .clk    (clk),
        .rst    (rst),
        .load_i (start_ok),
        .en_i   (absorb),
        .din_i  (sig_next),
        .sig_o  (sig_cur)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else if (abort_w) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= RUN_ENTRY;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                WARMUP: begin
                    if (cnt_q == WARM_LAST) begin
                        state_q <= COMPACT;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                COMPACT: begin
                    if (cnt_q == SAMP_LAST) begin
                        state_q <= DONE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        // Compare the value being written this edge, not the
                        // one currently held, so pass lines up with done.
                        pass_q  <= (sig_next == expected_sig);
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_cur;

endmodule

// File: tb/tb_bitxor_result_misr.sv
module tb_bitxor_result_misr;

    localparam logic [15:0] POLY = 16'h8016;

    logic        clk = 1'b0;
    logic        rst;
    logic        abort;
    logic [15:0] result;
    logic [15:0] expected_sig;
    logic        start_a, start_b, start_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic        pass_a, pass_b, pass_c;
    logic [15:0] sig_a, sig_b, sig_c;

    int checks   = 0;
    int failures = 0;
    int cur_sel  = 0;

    logic        sel_busy, sel_done, sel_pass;
    logic [15:0] sel_sig;

    logic [15:0] sb_sig[$];
    logic        sb_pass[$];

    always #5 clk = ~clk;

    // A: default parameters
    bitxor_result_misr u_dut_a (
        .clk (clk), .rst (rst),
`ifdef BITXOR_MISR_ABORT_EN
        .abort (abort),
`endif
        .start (start_a), .result (result), .expected_sig (expected_sig),
        .busy (busy_a), .done (done_a), .pass (pass_a), .signature (sig_a)
    );

    // B: single sample, zero seed
    bitxor_result_misr #(.NUM_SAMPLES(1), .SEED(16'h0000)) u_dut_b (
        .clk (clk), .rst (rst),
`ifdef BITXOR_MISR_ABORT_EN
        .abort (abort),
`endif
        .start (start_b), .result (result), .expected_sig (expected_sig),
        .busy (busy_b), .done (done_b), .pass (pass_b), .signature (sig_b)
    );

    // C: one-cycle warm-up, two samples, zero seed
    bitxor_result_misr #(.WARMUP_CYCLES(1), .NUM_SAMPLES(2), .SEED(16'h0000)) u_dut_c (
        .clk (clk), .rst (rst),
`ifdef BITXOR_MISR_ABORT_EN
        .abort (abort),
`endif
        .start (start_c), .result (result), .expected_sig (expected_sig),
        .busy (busy_c), .done (done_c), .pass (pass_c), .signature (sig_c)
    );

    always_comb begin
        sel_busy = busy_a; sel_done = done_a; sel_pass = pass_a; sel_sig = sig_a;
        if (cur_sel == 1) begin
            sel_busy = busy_b; sel_done = done_b; sel_pass = pass_b; sel_sig = sig_b;
        end else if (cur_sel == 2) begin
            sel_busy = busy_c; sel_done = done_c; sel_pass = pass_c; sel_sig = sig_c;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] model_step(input logic [15:0] s, input logic [15:0] r);
        logic [15:0] t;
        t = {s[14:0], 1'b0};
        if (s[15]) t = t ^ POLY;
        return t ^ r;
    endfunction

    task automatic set_start(input int sel, input logic v);
        start_a = (sel == 0) ? v : 1'b0;
        start_b = (sel == 1) ? v : 1'b0;
        start_c = (sel == 2) ? v : 1'b0;
    endtask

    // pat: 0 random, 1 all zero, 2 0001 then 0000, 3 constant A5A5.
    // Call on a negedge; returns on a negedge.
    task automatic run(input int sel, input int warm, input int n, input logic [15:0] seed,
                       input int pat, input bit want_pass, input bit poke, input int abort_k);
        logic [15:0] vals[$];
        logic [15:0] s, r, held;
        int busy_cnt, done_at, done_seen, limit;
        cur_sel = sel;
        s = seed;
        for (int i = 0; i < n; i++) begin
            case (pat)
                1:       r = 16'h0000;
                2:       r = (i == 0) ? 16'h0001 : 16'h0000;
                3:       r = 16'hA5A5;
                default: r = 16'($urandom);
            endcase
            vals.push_back(r);
            s = model_step(s, r);
        end
        sb_sig.push_back(s);
        sb_pass.push_back(want_pass);
        expected_sig = want_pass ? s : (s ^ 16'h0001);
        // negedge 0: start sampled at the next posedge (e0)
        set_start(sel, 1'b1);
        result   = 16'($urandom);
        busy_cnt = 0; done_at = 0; done_seen = 0; held = '0;
        limit    = warm + n + ((abort_k != 0) ? 3 : 20);
        for (int k = 1; k <= limit && (done_at == 0 || abort_k != 0); k++) begin
            @(negedge clk);
            set_start(sel, poke && (k == 2 || k == warm + 3));
            result = (k >= warm && k < warm + n) ? vals[k - warm] : 16'($urandom);
            if (k == 1) check("sig_seed_reload", 32'(sel_sig), 32'(seed));
            if (sel_busy) busy_cnt++;
            if (sel_done) begin
                done_seen++;
                if (done_at == 0) done_at = k;
            end
            if (abort_k != 0 && k == abort_k + 1) begin
                check("abort_busy", 32'(sel_busy), 32'd0);
                check("abort_done", 32'(sel_done), 32'd0);
                check("abort_sig_hold", 32'(sel_sig), 32'(held));
                abort = 1'b0;
            end
            if (abort_k != 0 && k == abort_k) begin
                held  = sel_sig;
                abort = 1'b1;
            end
        end
        set_start(sel, 1'b0);
        if (abort_k != 0) begin
            check("abort_no_done", 32'(done_seen), 32'd0);
            void'(sb_sig.pop_front());
            void'(sb_pass.pop_front());
        end else begin
            check("done_cycle", 32'(done_at), 32'(warm + n));
            check("busy_cycles", 32'(busy_cnt), 32'(warm + n - 1));
            check("signature", 32'(sel_sig), 32'(sb_sig.pop_front()));
            check("pass", 32'(sel_pass), 32'(sb_pass.pop_front()));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; abort = 1'b0; result = '0; expected_sig = '0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_pass", 32'(pass_a), 32'd0);
        check("rst_sig_a", 32'(sig_a), 32'hFFFF);
        check("rst_sig_b", 32'(sig_b), 32'h0000);

        // Random runs on the default configuration, matching and mismatching.
        run(0, 4, 256, 16'hFFFF, 0, 1'b1, 1'b0, 0);
        run(0, 4, 256, 16'hFFFF, 0, 1'b0, 1'b0, 0);
        // Extra start pulses in WARMUP and COMPACT must be ignored.
        run(0, 4, 256, 16'hFFFF, 0, 1'b1, 1'b1, 0);

        // Reset in the middle of COMPACT after 10 samples.
        cur_sel = 0;
        start_a = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start_a = 1'b0;
            result  = 16'($urandom);
        end
        check("busy_before_rst", 32'(busy_a), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_done", 32'(done_a), 32'd0);
        check("midrst_pass", 32'(pass_a), 32'd0);
        check("midrst_sig", 32'(sig_a), 32'hFFFF);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_idle", 32'(busy_a), 32'd0);

        // Single sample A5A5 with zero seed.
        run(1, 4, 1, 16'h0000, 3, 1'b1, 1'b0, 0);
        check("single_sig_const", 32'(sig_b), 32'hA5A5);
        // Two samples 0001, 0000 -> 0002; compare against 0003 fails.
        run(2, 1, 2, 16'h0000, 2, 1'b0, 1'b0, 0);
        check("two_sig_const", 32'(sig_c), 32'h0002);
        // Zero stream re-run from DONE reloads seed.
        run(2, 1, 2, 16'h0000, 1, 1'b1, 1'b0, 0);
        check("zero_sig_const", 32'(sig_c), 32'h0000);

`ifdef BITXOR_MISR_ABORT_EN
        begin
            logic [15:0] held_sig;
            run(0, 4, 256, 16'hFFFF, 0, 1'b1, 1'b0, 0);
            cur_sel  = 0;
            held_sig = sig_a;
            abort    = 1'b1;
            start_a  = 1'b1;
            @(negedge clk);
            abort    = 1'b0;
            start_a  = 1'b0;
            check("abort_start_done", 32'(done_a), 32'd0);
            check("abort_start_busy", 32'(busy_a), 32'd0);
            check("abort_start_sig", 32'(sig_a), 32'(held_sig));
            run(0, 4, 256, 16'hFFFF, 0, 1'b1, 1'b0, 4 + 256 - 1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bitxor_result_misr.md
# bitxor_result_misr

Downstream signature-compaction stage for the flopped bitwise-XOR test wrapper. It consumes the wrapper's per-cycle `result` stream, skips the wrapper's pipeline latency, and folds a fixed number of results into a multiple-input signature register (MISR). It then compares the signature against an expected value, which gives the physical-design flow a single pass/fail observation point per run.

## Interface
Parameters:
- BITWIDTH, 16, width of `result`, `expected_sig` and `signature`
- WARMUP_CYCLES, 4, latency of the upstream flopped stage; legal range ≥1
- NUM_SAMPLES, 256, number of results absorbed per run; legal range ≥1
- POLY, 16'h8016, MISR feedback polynomial, applied when the shifted-out MSB is 1
- SEED, 16'hFFFF, signature value loaded on start and on reset

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a run; honoured only in IDLE and DONE
- result  in  BITWIDTH  output of the upstream XOR stage
- expected_sig  in  BITWIDTH  golden signature; sampled on the final absorb edge
- busy  out  1  high in WARMUP and COMPACT
- done  out  1  high in DONE
- pass  out  1  registered compare result; valid while `done` is high
- signature  out  BITWIDTH  current MISR contents

## Operation
The block is a state machine with four states: IDLE, WARMUP, COMPACT and DONE.
- **IDLE.** `start` moves the block to WARMUP (or straight to COMPACT when WARMUP_CYCLES==1). On that move: signature←SEED, count←0.
- **WARMUP.** `result` is ignored. The counter increments each edge. After WARMUP_CYCLES−1 edges in WARMUP the block moves to COMPACT with count←0.
- **COMPACT.** Each edge absorbs one result: sig ← {sig[W-2:0],1'b0} ^ (sig[W-1] ? POLY : 0) ^ result.
  - At count==NUM_SAMPLES−1 the block moves to DONE.
  - On that same edge: pass ← (sig_next == expected_sig).
- **DONE.** Signature and pass hold. `start` re-runs the sequence exactly as from IDLE, including the SEED reload.
- **start while busy.** `start` in WARMUP or COMPACT is ignored. There is no restart mid-run.
- **Reset (any state, any time).** state=IDLE, signature=SEED, busy=0, done=0, pass=0, count=0. A reset mid-run discards the partial signature.
- **Counter width.** clog2(max(WARMUP_CYCLES, NUM_SAMPLES)+1). The counter never wraps within a run.
- **Arithmetic.** All arithmetic is modulo 2^BITWIDTH. There is no carry and no saturation.

## Timing
- Let e0 be the edge that samples `start`. The first result absorbed is the one sampled at edge e0+WARMUP_CYCLES.
  - Consequence: when `start` is asserted in the same cycle the first operand pair is presented upstream, that pair's result is absorbed first.
- The last result is absorbed at edge e0+WARMUP_CYCLES+NUM_SAMPLES−1.
- `done` and `pass` are visible in the cycle after that edge.
- `busy` rises after e0 and falls together with the rise of `done`.
- `signature` updates one edge after each absorbed result.
- Every output is registered; there is no combinational input-to-output path.

## Configuration
- **BITXOR_MISR_ABORT_EN defined:** adds port `abort` (in, 1).
  - `abort` high in WARMUP, COMPACT or DONE forces IDLE on the next edge: busy=0, done=0, pass=0, signature holds its last value.
  - `abort` has priority over `start` and over the final-absorb transition.
  - `abort` in IDLE has no effect.
- **Not defined:** the `abort` port is absent. A run can be terminated only by `rst`.

## Structure
- **Shared package `bitxor_misr_pkg`:**
  - state enum {IDLE, WARMUP, COMPACT, DONE}, 2-bit encoding
  - default POLY and SEED constants
  - a `misr_next` function implementing the update equation
- **Sub-module `bitxor_misr_reg`:** the BITWIDTH-bit signature register.
  - Inputs: load (SEED), enable (absorb), data in.
  - It takes the same clk/rst.
  - The top-level FSM and counter drive it.

## Test plan
- Reset mid-COMPACT (rst pulsed at sample 10) → next cycle: busy=0, done=0, pass=0, signature=16'hFFFF, state IDLE.
- NUM_SAMPLES=1, SEED=0, WARMUP_CYCLES=4, result=16'hA5A5 at e0+4, expected_sig=16'hA5A5 → signature=16'hA5A5, done=1 and pass=1 one cycle after e0+4; busy high for exactly 4 cycles.
- NUM_SAMPLES=2, SEED=0, results 16'h0001 then 16'h0000 → signature=16'h0002. With expected_sig=16'h0003: pass=0, done=1.
- SEED=0, result held at 0 for 256 samples → signature=0. A second `start` in DONE reloads SEED and repeats with identical timing.
- `start` pulsed again during WARMUP and COMPACT → ignored; `done` timing and signature are identical to a single-start run.
- With BITXOR_MISR_ABORT_EN: `abort` and `start` high together in DONE → IDLE, done=0, signature unchanged. `abort` on the final absorb edge → IDLE, done never rises.
